// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the hazard/scoreboard unit.
`default_nettype none

package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_W    = 2'b01,
      FWD_M    = 2'b10
   } fwd_sel_e;

   localparam logic [1:0] RES_LOAD = 2'b01;

endpackage

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write bits with one set port,
// one clear port and three combinational read ports.
`default_nettype none

module reg_scoreboard #(
   parameter int NREGS = 32,
   localparam int RW   = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          set_en,
   input  logic [RW-1:0] set_idx,
   input  logic          clr_en,
   input  logic [RW-1:0] clr_idx,
   input  logic [RW-1:0] rd_idx0,
   input  logic [RW-1:0] rd_idx1,
   input  logic [RW-1:0] rd_idx2,
   output logic          rd_val0,
   output logic          rd_val1,
   output logic          rd_val2
);

   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] pending_next;

   // Clear is applied first so a same-cycle set of the same register wins.
   always_comb begin
      pending_next = pending;
      if (clr_en)
         pending_next[clr_idx] = 1'b0;
      if (set_en && (set_idx != '0))
         pending_next[set_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pending <= '0;
      else
         pending <= pending_next;
   end

   assign rd_val0 = pending[rd_idx0];
   assign rd_val1 = pending[rd_idx1];
   assign rd_val2 = pending[rd_idx2];

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: forwarding, stall/flush control, pending-write
// scoreboard for the long-latency unit, watchdog and performance counters.
`default_nettype none

module hazard_scoreboard_unit
   import hazard_pkg::*;
#(
   parameter int NREGS   = 32,
   parameter int PERF_W  = 32,
   parameter int TIMEOUT = 1024,
   localparam int RW     = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [RW-1:0]     Rs1_D,
   input  logic [RW-1:0]     Rs2_D,
   input  logic [RW-1:0]     Rd_D,
   input  logic              lng_D,
   input  logic              is_jalr_D,
   input  logic [RW-1:0]     Rs1_E,
   input  logic [RW-1:0]     Rs2_E,
   input  logic [RW-1:0]     Rd_E,
   input  logic [1:0]        ResultSrc_E,
   input  logic              RegWrite_E,
   input  logic              PCSrc_E,
   input  logic              lng_E,
   input  logic [RW-1:0]     Rd_M,
   input  logic [RW-1:0]     Rd_W,
   input  logic              RegWrite_M,
   input  logic              RegWrite_W,
   input  logic              lng_busy,
   input  logic              lng_done,
   input  logic [RW-1:0]     lng_rd,
   output logic [1:0]        ForwardA_E,
   output logic [1:0]        ForwardB_E,
   output logic              Stall_F,
   output logic              Stall_D,
   output logic              Flush_D,
   output logic              Flush_E,
   output logic              Flush_M,
   output logic              sb_timeout,
   output logic [PERF_W-1:0] perf_stall,
   output logic [PERF_W-1:0] perf_flush,
   output logic [PERF_W-1:0] perf_sb_stall
);

   localparam int            CW     = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT);

   fwd_sel_e fwd_a, fwd_b;
   logic     pend_rs1, pend_rs2, pend_rd;
   logic     lw_stall, jalr_stall, lng_e_stall, sb_stall, struct_stall;
   logic     any_stall, stall_d;
   logic [CW-1:0] wd_cnt, wd_next;

   always_comb begin
      fwd_a = FWD_NONE;
      fwd_b = FWD_NONE;
      if (Rs1_E != '0 && Rs1_E == Rd_M && RegWrite_M)
         fwd_a = FWD_M;
      else if (Rs1_E != '0 && Rs1_E == Rd_W && RegWrite_W)
         fwd_a = FWD_W;
      if (Rs2_E != '0 && Rs2_E == Rd_M && RegWrite_M)
         fwd_b = FWD_M;
      else if (Rs2_E != '0 && Rs2_E == Rd_W && RegWrite_W)
         fwd_b = FWD_W;
   end

   assign ForwardA_E = fwd_a;
   assign ForwardB_E = fwd_b;

   reg_scoreboard #(.NREGS(NREGS)) u_sb (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_en  (lng_E),
      .set_idx (Rd_E),
      .clr_en  (lng_done),
      .clr_idx (lng_rd),
      .rd_idx0 (Rs1_D),
      .rd_idx1 (Rs2_D),
      .rd_idx2 (Rd_D),
      .rd_val0 (pend_rs1),
      .rd_val1 (pend_rs2),
      .rd_val2 (pend_rd)
   );

   // The long op issuing this cycle is not yet in the scoreboard; lng_e_stall covers that gap.
   assign lw_stall     = (ResultSrc_E == RES_LOAD) && (Rd_E != '0) &&
                         ((Rs1_D == Rd_E) || (Rs2_D == Rd_E));
   assign jalr_stall   = is_jalr_D && (Rs1_D != '0) && (Rs1_D == Rd_E) && (RegWrite_E || lng_E);
   assign lng_e_stall  = lng_E && (Rd_E != '0) &&
                         ((Rs1_D == Rd_E) || (Rs2_D == Rd_E) || (Rd_D == Rd_E));
   assign sb_stall     = pend_rs1 || pend_rs2 || pend_rd;
   assign struct_stall = lng_D && (lng_busy || lng_E);
   assign any_stall    = lw_stall || jalr_stall || lng_e_stall || sb_stall || struct_stall;

   assign stall_d = any_stall && !PCSrc_E;
   assign Stall_F = stall_d;
   assign Stall_D = stall_d;
   assign Flush_D = PCSrc_E;
   assign Flush_E = PCSrc_E || any_stall;
   assign Flush_M = 1'b0;

   always_comb begin
      wd_next = '0;
      if (sb_stall && !PCSrc_E)
         wd_next = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt     <= '0;
         sb_timeout <= 1'b0;
      end else begin
         wd_cnt <= wd_next;
         if (wd_next == WD_MAX)
            sb_timeout <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall    <= '0;
         perf_flush    <= '0;
         perf_sb_stall <= '0;
      end else begin
         if (stall_d && (perf_stall != '1))
            perf_stall <= perf_stall + PERF_W'(1);
         if (PCSrc_E && (perf_flush != '1))
            perf_flush <= perf_flush + PERF_W'(1);
         if (stall_d && sb_stall && (perf_sb_stall != '1))
            perf_sb_stall <= perf_sb_stall + PERF_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench: directed steps plus randomized traffic against a
// behavioural model of the hazard/scoreboard rules.
`default_nettype none

module tb_hazard_scoreboard_unit;
   import hazard_pkg::*;

   localparam int NREGS   = 32;
   localparam int RW      = 5;
   localparam int PERF_W  = 8;
   localparam int TIMEOUT = 8;
   localparam int PMAX    = (1 << PERF_W) - 1;

   logic clk = 1'b0;
   logic rst_n;
   logic [RW-1:0] Rs1_D, Rs2_D, Rd_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W, lng_rd;
   logic lng_D, is_jalr_D, RegWrite_E, PCSrc_E, lng_E, RegWrite_M, RegWrite_W;
   logic lng_busy, lng_done;
   logic [1:0] ResultSrc_E, ForwardA_E, ForwardB_E;
   logic Stall_F, Stall_D, Flush_D, Flush_E, Flush_M, sb_timeout;
   logic [PERF_W-1:0] perf_stall, perf_flush, perf_sb_stall;

   int errors = 0;
   int checks = 0;

   bit m_pend [NREGS];
   int m_wd, m_ps, m_pf, m_psb;
   bit m_to;

   always #5 clk = ~clk;

   hazard_scoreboard_unit #(.NREGS(NREGS), .PERF_W(PERF_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D), .lng_D(lng_D), .is_jalr_D(is_jalr_D),
      .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E), .ResultSrc_E(ResultSrc_E),
      .RegWrite_E(RegWrite_E), .PCSrc_E(PCSrc_E), .lng_E(lng_E),
      .Rd_M(Rd_M), .Rd_W(Rd_W), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
      .lng_busy(lng_busy), .lng_done(lng_done), .lng_rd(lng_rd),
      .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
      .Stall_F(Stall_F), .Stall_D(Stall_D),
      .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_M(Flush_M),
      .sb_timeout(sb_timeout),
      .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_sb_stall(perf_sb_stall)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_idle();
      Rs1_D = '0; Rs2_D = '0; Rd_D = '0; lng_D = 0; is_jalr_D = 0;
      Rs1_E = '0; Rs2_E = '0; Rd_E = '0; ResultSrc_E = 2'b00; RegWrite_E = 0;
      PCSrc_E = 0; lng_E = 0; Rd_M = '0; Rd_W = '0; RegWrite_M = 0; RegWrite_W = 0;
      lng_busy = 0; lng_done = 0; lng_rd = '0;
   endtask

   task automatic model_clear();
      foreach (m_pend[i]) m_pend[i] = 0;
      m_wd = 0; m_to = 0; m_ps = 0; m_pf = 0; m_psb = 0;
   endtask

   function automatic int fwd_ref(input int rs);
      if (rs != 0 && rs == int'(Rd_M) && RegWrite_M) return 2;
      if (rs != 0 && rs == int'(Rd_W) && RegWrite_W) return 1;
      return 0;
   endfunction

   function automatic bit sb_ref();
      return m_pend[Rs1_D] || m_pend[Rs2_D] || m_pend[Rd_D];
   endfunction

   function automatic bit any_ref();
      int r1 = int'(Rs1_D), r2 = int'(Rs2_D), rd = int'(Rd_D), re = int'(Rd_E);
      bit lw = (ResultSrc_E == 2'b01) && re != 0 && (r1 == re || r2 == re);
      bit jr = is_jalr_D && r1 != 0 && r1 == re && (RegWrite_E || lng_E);
      bit le = lng_E && re != 0 && (r1 == re || r2 == re || rd == re);
      bit st = lng_D && (lng_busy || lng_E);
      return lw || jr || le || sb_ref() || st;
   endfunction

   task automatic check_model();
      bit any = any_ref();
      bit stl = any && !PCSrc_E;
      chk("fwd_a", ForwardA_E, fwd_ref(int'(Rs1_E)));
      chk("fwd_b", ForwardB_E, fwd_ref(int'(Rs2_E)));
      chk("stall_f", Stall_F, stl);
      chk("stall_d", Stall_D, stl);
      chk("flush_d", Flush_D, PCSrc_E);
      chk("flush_e", Flush_E, PCSrc_E || any);
      chk("flush_m", Flush_M, 0);
      chk("sb_timeout", sb_timeout, m_to);
      chk("perf_stall", perf_stall, m_ps);
      chk("perf_flush", perf_flush, m_pf);
      chk("perf_sb_stall", perf_sb_stall, m_psb);
   endtask

   task automatic model_update();
      bit sb  = sb_ref();
      bit stl = any_ref() && !PCSrc_E;
      if (lng_done) m_pend[lng_rd] = 0;
      if (lng_E && Rd_E != 0) m_pend[Rd_E] = 1;
      m_wd = (sb && !PCSrc_E) ? ((m_wd < TIMEOUT) ? m_wd + 1 : TIMEOUT) : 0;
      if (m_wd == TIMEOUT) m_to = 1;
      if (stl && m_ps < PMAX) m_ps++;
      if (PCSrc_E && m_pf < PMAX) m_pf++;
      if (stl && sb && m_psb < PMAX) m_psb++;
   endtask

   // Called with inputs already set, shortly after a falling edge.
   task automatic step();
      #1;
      check_model();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2 rst_n = 0;
      #1 model_clear();
      check_model();
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      set_idle();
      rst_n = 0;
      model_clear();
      @(negedge clk);
      #1;
      chk("rst_timeout", sb_timeout, 0);
      chk("rst_perf_stall", perf_stall, 0);
      check_model();
      rst_n = 1;
      @(negedge clk);

      // Forwarding priority and x0 exclusion
      Rd_M = 5; Rd_W = 5; RegWrite_M = 1; RegWrite_W = 1; Rs1_E = 5;
      #1 chk("fwd_a_m", ForwardA_E, 2'b10);
      step();
      Rs1_E = 0;
      #1 chk("fwd_a_x0", ForwardA_E, 2'b00);
      step();
      RegWrite_M = 0; Rs2_E = 5;
      #1 chk("fwd_b_w", ForwardB_E, 2'b01);
      step();
      set_idle();

      // Load-use on x7
      ResultSrc_E = RES_LOAD; Rd_E = 7; Rs2_D = 7;
      #1;
      chk("lw_stall_f", Stall_F, 1);
      chk("lw_stall_d", Stall_D, 1);
      chk("lw_flush_e", Flush_E, 1);
      step();
      set_idle();
      #1 chk("lw_perf_stall", perf_stall, 1);
      step();

      // Long op to x9, consumer waits, completion in the 20th scoreboard cycle
      lng_E = 1; Rd_E = 9; Rs1_D = 9;
      #1 chk("lng_cycle0", Stall_D, 1);
      step();
      lng_E = 0; Rd_E = 0;
      for (int c = 1; c <= 20; c++) begin
         if (c == 20) begin lng_done = 1; lng_rd = 9; end
         #1 chk("lng_sb_stall", Stall_D, 1);
         step();
      end
      lng_done = 0;
      #1;
      chk("lng_released", Stall_D, 0);
      chk("lng_perf_sb", perf_sb_stall, 20);
      chk("lng_perf_stall", perf_stall, 22);
      chk("wd_tripped", sb_timeout, 1);
      step();
      set_idle();
      repeat (3) step();
      chk("wd_sticky", sb_timeout, 1);
      do_reset();
      chk("wd_cleared", sb_timeout, 0);

      // Same-cycle set and clear of x4: set wins
      lng_E = 1; Rd_E = 4;
      step();
      lng_done = 1; lng_rd = 4;
      step();
      set_idle();
      Rs1_D = 4;
      #1 chk("set_wins", Stall_D, 1);
      step();
      Rs1_D = 0; lng_done = 1; lng_rd = 4;
      step();
      set_idle();

      // Redirect overrides a scoreboard stall
      lng_E = 1; Rd_E = 3;
      step();
      set_idle();
      Rs1_D = 3; PCSrc_E = 1;
      #1;
      chk("redir_stall_f", Stall_F, 0);
      chk("redir_flush_d", Flush_D, 1);
      chk("redir_flush_e", Flush_E, 1);
      step();
      PCSrc_E = 0; Rs1_D = 0;
      #1 chk("redir_perf_flush", perf_flush, 1);
      step();

      // Reset mid-operation drops x3's pending bit
      do_reset();
      Rs1_D = 3;
      #1 chk("rst_drops_pending", Stall_D, 0);
      step();
      set_idle();

      // Randomized traffic on a small register window to provoke hazards
      for (int i = 0; i < 600; i++) begin
         Rs1_D = RW'($urandom_range(0, 7));
         Rs2_D = RW'($urandom_range(0, 7));
         Rd_D  = RW'($urandom_range(0, 7));
         lng_D = ($urandom_range(0, 3) == 0);
         is_jalr_D = ($urandom_range(0, 3) == 0);
         Rs1_E = RW'($urandom_range(0, 7));
         Rs2_E = RW'($urandom_range(0, 7));
         Rd_E  = RW'($urandom_range(0, 7));
         ResultSrc_E = 2'($urandom_range(0, 3));
         RegWrite_E = $urandom_range(0, 1) == 1;
         PCSrc_E = ($urandom_range(0, 7) == 0);
         lng_E = ($urandom_range(0, 3) == 0);
         Rd_M = RW'($urandom_range(0, 7));
         Rd_W = RW'($urandom_range(0, 7));
         RegWrite_M = $urandom_range(0, 1) == 1;
         RegWrite_W = $urandom_range(0, 1) == 1;
         lng_busy = ($urandom_range(0, 3) == 0);
         lng_done = ($urandom_range(0, 1) == 0);
         lng_rd = RW'($urandom_range(0, 7));
         if (i == 300) do_reset();
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised successor to the core's hazard logic, supporting variable-latency units (multi-cycle mul/div, non-blocking loads) alongside the single-cycle pipeline. Keeps M/W operand forwarding, load-use and JALR stalls, and branch flushes. Adds:
- a per-register pending-write scoreboard;
- a structural stall for the single long-latency unit;
- a scoreboard watchdog;
- saturating performance counters.

Sits beside the pipeline registers and drives their stall/flush enables.

## Interface
Parameters:
- NREGS, 32, architectural register count; index width RW = $clog2(NREGS)
- PERF_W, 32, width of each performance counter
- TIMEOUT, 1024, consecutive scoreboard-stall cycles before watchdog trips; counter width $clog2(TIMEOUT+1)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- Rs1_D, Rs2_D, Rd_D  in  RW each  Decode register indices
- lng_D  in  1  Decode instruction is a long-latency op
- is_jalr_D  in  1  Decode instruction is JALR
- Rs1_E, Rs2_E, Rd_E  in  RW each  Execute register indices
- ResultSrc_E  in  2  2'b01 = load
- RegWrite_E  in  1  Execute write enable
- PCSrc_E  in  1  branch/jump taken in Execute
- lng_E  in  1  Execute instruction issues to the long-latency unit this cycle
- Rd_M, Rd_W  in  RW each  M/W destinations
- RegWrite_M, RegWrite_W  in  1 each  M/W write enables
- lng_busy  in  1  long-latency unit cannot accept an op
- lng_done  in  1  long-latency result writes back this cycle
- lng_rd  in  RW  destination of the completing result
- ForwardA_E, ForwardB_E  out  2 each  fwd_sel_e
- Stall_F, Stall_D  out  1 each  hold PC / IF-ID register
- Flush_D, Flush_E, Flush_M  out  1 each  clear pipeline registers
- sb_timeout  out  1  sticky watchdog error
- perf_stall, perf_flush, perf_sb_stall  out  PERF_W each  counters

## Operation
Forwarding (combinational):
- Source M is selected (FWD_M) if Rs==Rd_M && RegWrite_M && Rs!=0.
- Otherwise source W is selected (FWD_W) if Rs==Rd_W && RegWrite_W && Rs!=0.
- Otherwise FWD_NONE.
- Long ops travel with RegWrite=0. Their result enters the W-stage write signals on completion.

Scoreboard, pending[NREGS]:
- On lng_E && Rd_E!=0, set pending[Rd_E] at the clock edge.
- On lng_done, clear pending[lng_rd].
- Same register set and cleared in the same cycle: set wins.
- pending[0] is never set.

Stall terms:
- lwStall = ResultSrc_E==01 && Rd_E!=0 && (Rs1_D==Rd_E || Rs2_D==Rd_E)
- jalrStall = is_jalr_D && Rs1_D!=0 && ((RegWrite_E && Rs1_D==Rd_E) || (lng_E && Rs1_D==Rd_E))
- lngEStall = lng_E && Rd_E!=0 && (Rs1_D==Rd_E || Rs2_D==Rd_E || Rd_D==Rd_E)
- sbStall = pending[Rs1_D] || pending[Rs2_D] || pending[Rd_D] (RAW and WAW)
- structStall = lng_D && (lng_busy || lng_E)
- anyStall = OR of all five terms

Pipeline controls:
- Stall_F = Stall_D = anyStall && !PCSrc_E. A redirect overrides the stall because the stalled instruction is on the wrong path.
- Flush_D = PCSrc_E
- Flush_E = PCSrc_E || anyStall
- Flush_M = 0

Watchdog:
- A counter increments on each cycle where sbStall && !PCSrc_E, and clears to 0 on any other cycle.
- When the counter reaches TIMEOUT, sb_timeout sets and stays set until reset.
- The counter saturates at TIMEOUT.

Performance counters (saturate at all-ones):
- perf_stall increments on cycles with Stall_D.
- perf_flush increments on cycles with PCSrc_E.
- perf_sb_stall increments on cycles with Stall_D && sbStall.

## Timing
- Reset (async assert, sync release):
  - pending, watchdog counter, sb_timeout and all perf counters go to 0.
  - All combinational outputs are then 0 unless inputs drive them.
- Forwarding, stall and flush outputs have zero-cycle latency from their inputs.
- A scoreboard set at edge N is visible to Decode in cycle N+1. lngEStall covers cycle N.
- A completion in cycle N releases the stall from cycle N+1. The consumer reads the value via W forwarding or the register file.
- Counters update at the edge ending the counted cycle.
- Reset mid-operation drops all pending bits. The core discards in-flight long ops on reset.

## Structure
- Package hazard_pkg:
  - typedef enum logic [1:0] fwd_sel_e: FWD_NONE=2'b00, FWD_W=2'b01, FWD_M=2'b10
  - localparam RES_LOAD=2'b01
- Sub-module reg_scoreboard:
  - Parameter NREGS.
  - Holds the pending vector with set/clear ports.
  - Provides three combinational read ports.

## Test plan
- Rd_M=5 and Rd_W=5 with both write enables, Rs1_E=5 -> ForwardA_E=10. Same with Rs1_E=0 -> 00.
- Load to x7 in E, Rs2_D=7 -> Stall_F=Stall_D=Flush_E=1 for one cycle, perf_stall +1.
- lng_E with Rd_E=9, then Rs1_D=9 for 20 cycles, then lng_done with lng_rd=9 -> stall for 21 cycles (cycle 0 via lngEStall), released the cycle after done, perf_sb_stall=20.
- Same-cycle lng_done(lng_rd=4) and lng_E(Rd_E=4) -> pending[4] remains 1.
- pending[3] set, Rs1_D=3, PCSrc_E=1 -> Stall_F=0, Flush_D=Flush_E=1, perf_flush +1.
- TIMEOUT=8, sbStall held 8 cycles -> sb_timeout=1 and stays 1 after the stall clears, until rst_n low.
